mem_writeback: RTL and testbench
================================

Name: mem_writeback

Overview:
- Consumer end of the EX→WB pipeline register interface in the 3-stage RV32I pipeline.
- Takes the registered execute result and control, and performs the data-memory load or store over a req/ready/rvalid handshake.
- Aligns and extends load data, drives the register-file write port, and provides forwarding.
- Raises stall_read back to the execute stage while a memory access is outstanding. The EX→WB register holds while stall_read=1.

Parameters:
TIMEOUT, 16, maximum cycles spent in LOAD_WAIT before the load is aborted with bus_err (range 1..255).

Ports:
clk  input  1  clock; all state changes on the rising edge
reset  input  1  asynchronous, active-low reset
wb_result  input  32  ALU result, or store data for stores
wb_mem_addr  input  32  registered data-memory byte address
wb_mem_write  input  1  store instruction in WB
wb_mem_to_reg  input  1  load instruction in WB
wb_alu_to_reg  input  1  instruction writes rd
wb_dest_reg_sel  input  5  rd index
wb_read_address  input  2  byte offset of the load/store (equals wb_mem_addr[1:0])
mem_alu_operation  input  3  funct3: LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
dmem_req  output  1  memory request valid
dmem_we  output  1  1=store, 0=load
dmem_addr  output  32  word address; wb_mem_addr with bits [1:0] forced to 0
dmem_wdata  output  32  store data, lane-replicated
dmem_be  output  4  byte enables
dmem_ready  input  1  request accepted this cycle
dmem_rvalid  input  1  load data valid
dmem_rdata  input  32  load data
rf_we  output  1  register-file write enable
rf_waddr  output  5  write index
rf_wdata  output  32  write data
fwd_valid  output  1  equals rf_we; for the operand bypass
fwd_data  output  32  equals rf_wdata
stall_read  output  1  hold the EX→WB register
misaligned_err  output  1  registered one-cycle pulse
bus_err  output  1  registered one-cycle pulse

Behaviour:
- FSM states: IDLE, LOAD_WAIT. Internal wait counter is 8 bits.
- Reset (reset=0, asynchronous): state=IDLE, counter=0, misaligned_err=0, bus_err=0.
  - Any in-flight load is dropped; no rf write occurs for it.
  - With the all-zero reset inputs from the EX→WB register, every combinational output is 0.
- Misaligned access:
  - Condition: halfword with offset[0]=1, or word with offset!=0.
  - dmem_req=0, rf_we=0, stall_read=0.
  - misaligned_err=1 in the next cycle only.
- Store (wb_mem_write=1, aligned, IDLE):
  - dmem_req=1, dmem_we=1, stall_read=!dmem_ready. The store completes on the edge where ready=1; no rf write.
  - SB: be=1<<offset, wdata={4{byte}}.
  - SH: be=0011 when offset[1]=0, else 1100; wdata={2{half}}.
  - SW: be=1111.
- Load in IDLE (wb_mem_to_reg=1, aligned):
  - dmem_req=1, dmem_we=0, dmem_be=1111.
  - ready=0: stay IDLE, stall_read=1.
  - ready=1 and rvalid=1: zero-wait completion; rf write this cycle, stall_read=0.
  - ready=1 and rvalid=0: go to LOAD_WAIT, stall_read=1, counter=0.
- LOAD_WAIT:
  - dmem_req=0. stall_read=!dmem_rvalid.
  - On rvalid: write rf, go to IDLE.
  - Otherwise the counter increments. When counter==TIMEOUT-1 without rvalid: pulse bus_err, go to IDLE, no rf write, stall_read=0 in that cycle.
- Load extraction:
  - Lane select by offset.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Non-memory instruction: rf_wdata=wb_result, rf_we=wb_alu_to_reg, no stall.
- rf_we is forced to 0 whenever wb_dest_reg_sel==0. rf_waddr=wb_dest_reg_sel.
- dmem_req is only issued from IDLE. A new op is never issued while in LOAD_WAIT.
- Simultaneous rvalid and timeout expiry: rvalid wins; data is written and bus_err is not raised.
- dmem_rvalid while in IDLE with no load pending is ignored.

Test Plan:
- ADD result: wb_result=0x1234, alu_to_reg=1, rd=5 → rf_we=1, waddr=5, wdata=0x1234, stall_read=0. Same with rd=0 → rf_we=0.
- SB: addr=0x103, data=0xAB, ready low for 2 cycles → stall_read=1 for 2 cycles; then be=1000, wdata=0xABABABAB, dmem_addr=0x100.
- LB: addr offset 2, rdata=0x00800000, ready=1, rvalid 3 cycles later → 3 stall cycles, then wdata=0xFFFFFF80. LBU with the same stimulus → 0x00000080.
- LH: offset 1 → misaligned_err pulse one cycle later, dmem_req=0, rf_we=0. SH: offset 2, data=0xBEEF → be=1100, wdata=0xBEEFBEEF.
- LW: rvalid never returns, TIMEOUT=16 → bus_err pulse after 16 LOAD_WAIT cycles, no rf write, FSM back to IDLE. rvalid in the final cycle → write, no bus_err.
- Reset asserted while in LOAD_WAIT → IDLE immediately, stall_read=0, and a late rvalid after reset release does not write.

Source files
------------

// File: rtl/mem_writeback.sv
// Write-back stage of the 3-stage RV32I pipeline.
// Performs the data-memory load/store of the instruction held in the EX->WB
// register, aligns and extends load data, drives the register-file write port
// and the forwarding bypass, and stalls the EX->WB register while a memory
// access is outstanding.
module mem_writeback #(
  parameter int unsigned TIMEOUT = 16  // max LOAD_WAIT cycles before bus_err (1..255)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wb_result,
  input  logic [31:0] wb_mem_addr,
  input  logic        wb_mem_write,
  input  logic        wb_mem_to_reg,
  input  logic        wb_alu_to_reg,
  input  logic [4:0]  wb_dest_reg_sel,
  input  logic [1:0]  wb_read_address,
  input  logic [2:0]  mem_alu_operation,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic        fwd_valid,
  output logic [31:0] fwd_data,
  output logic        stall_read,
  output logic        misaligned_err,
  output logic        bus_err
);

  typedef enum logic {
    IDLE,
    LOAD_WAIT
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        misaligned_err_d, bus_err_d;
  logic        rf_we_raw;

  logic        is_store, is_load, misaligned;
  logic [31:0] lane;
  logic [31:0] load_data;
  logic [3:0]  store_be;
  logic [31:0] store_wdata;

  // The memory is word addressed; the byte offset travels separately.
  logic unused_addr_bits;
  assign unused_addr_bits = ^wb_mem_addr[1:0];
  assign dmem_addr        = {wb_mem_addr[31:2], 2'b00};

  // A store wins if both memory flags are ever set together.
  assign is_store   = wb_mem_write;
  assign is_load    = wb_mem_to_reg && !wb_mem_write;
  assign misaligned = (is_store || is_load) &&
                      (((mem_alu_operation[1:0] == 2'b01) && wb_read_address[0]) ||
                       ((mem_alu_operation[1:0] == 2'b10) && (wb_read_address != 2'b00)));

  // Select the addressed byte/halfword lane and sign- or zero-extend it.
  always_comb begin
    lane = dmem_rdata >> {wb_read_address, 3'b000};
    case (mem_alu_operation)
      3'd0:    load_data = {{24{lane[7]}}, lane[7:0]};
      3'd1:    load_data = {{16{lane[15]}}, lane[15:0]};
      3'd4:    load_data = {24'd0, lane[7:0]};
      3'd5:    load_data = {16'd0, lane[15:0]};
      default: load_data = dmem_rdata;
    endcase
  end

  // Byte enables and lane-replicated write data for SB/SH/SW.
  always_comb begin
    case (mem_alu_operation[1:0])
      2'b00: begin
        store_be    = 4'b0001 << wb_read_address;
        store_wdata = {4{wb_result[7:0]}};
      end
      2'b01: begin
        store_be    = wb_read_address[1] ? 4'b1100 : 4'b0011;
        store_wdata = {2{wb_result[15:0]}};
      end
      default: begin
        store_be    = 4'b1111;
        store_wdata = wb_result;
      end
    endcase
  end

  // Next-state and output decode for the load/store handshake.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    state_d          = state_q;
    cnt_d            = cnt_q;
    dmem_req         = 1'b0;
    dmem_we          = 1'b0;
    dmem_be          = 4'b0000;
    dmem_wdata       = 32'd0;
    rf_we_raw        = 1'b0;
    rf_wdata         = wb_result;
    stall_read       = 1'b0;
    misaligned_err_d = 1'b0;
    bus_err_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (misaligned) begin
          misaligned_err_d = 1'b1;
        end else if (is_store) begin
          dmem_req   = 1'b1;
          dmem_we    = 1'b1;
          dmem_be    = store_be;
          dmem_wdata = store_wdata;
          stall_read = !dmem_ready;
        end else if (is_load) begin
          dmem_req = 1'b1;
          dmem_be  = 4'b1111;
          rf_wdata = load_data;
          if (!dmem_ready) begin
            stall_read = 1'b1;
          end else if (dmem_rvalid) begin
            rf_we_raw = 1'b1;
          end else begin
            state_d    = LOAD_WAIT;
            cnt_d      = 8'd0;
            stall_read = 1'b1;
          end
        end else begin
          rf_we_raw = wb_alu_to_reg;
        end
      end

      LOAD_WAIT: begin
        rf_wdata = load_data;
        // Data arriving in the last allowed cycle still counts as a hit.
        if (dmem_rvalid) begin
          rf_we_raw = 1'b1;
          state_d   = IDLE;
        end else if (cnt_q == LAST_WAIT) begin
          bus_err_d = 1'b1;
          state_d   = IDLE;
        end else begin
          cnt_d      = cnt_q + 8'd1;
          stall_read = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // x0 is hardwired to zero, so it is never written.
  assign rf_we     = rf_we_raw && (wb_dest_reg_sel != 5'd0);
  assign rf_waddr  = wb_dest_reg_sel;
  assign fwd_valid = rf_we;
  assign fwd_data  = rf_wdata;

  // State, wait counter and the registered error pulses.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      misaligned_err <= 1'b0;
      bus_err        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      misaligned_err <= misaligned_err_d;
      bus_err        <= bus_err_d;
    end
  end

endmodule

// File: tb/tb_mem_writeback.sv
// Self-checking bench for mem_writeback: directed scenarios followed by
// randomized ALU/load/store/misaligned transactions against a transaction-level
// reference model.
module tb_mem_writeback;

  localparam int TIMEOUT = 16;

  logic        clk;
  logic        reset;
  logic [31:0] wb_result;
  logic [31:0] wb_mem_addr;
  logic        wb_mem_write;
  logic        wb_mem_to_reg;
  logic        wb_alu_to_reg;
  logic [4:0]  wb_dest_reg_sel;
  logic [1:0]  wb_read_address;
  logic [2:0]  mem_alu_operation;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic        stall_read;
  logic        misaligned_err;
  logic        bus_err;

  int n_assert = 0;
  int n_fail   = 0;
  logic exp_mis = 1'b0;
  logic exp_bus = 1'b0;

  mem_writeback #(.TIMEOUT(TIMEOUT)) dut (
    .clk               (clk),
    .reset             (reset),
    .wb_result         (wb_result),
    .wb_mem_addr       (wb_mem_addr),
    .wb_mem_write      (wb_mem_write),
    .wb_mem_to_reg     (wb_mem_to_reg),
    .wb_alu_to_reg     (wb_alu_to_reg),
    .wb_dest_reg_sel   (wb_dest_reg_sel),
    .wb_read_address   (wb_read_address),
    .mem_alu_operation (mem_alu_operation),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ready        (dmem_ready),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .rf_we             (rf_we),
    .rf_waddr          (rf_waddr),
    .rf_wdata          (rf_wdata),
    .fwd_valid         (fwd_valid),
    .fwd_data          (fwd_data),
    .stall_read        (stall_read),
    .misaligned_err    (misaligned_err),
    .bus_err           (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
    logic [31:0] s, b, h;
    s = w >> (32'(off) * 8);
    b = s & 32'h0000_00FF;
    h = s & 32'h0000_FFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      3'd0:    return 4'(32'd1 << off);
      3'd1:    return (off >= 2'd2) ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wdata_model(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'd0:    return (d & 32'h0000_00FF) * 32'h0101_0101;
      3'd1:    return (d & 32'h0000_FFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic clear_inputs();
    wb_result         = 32'd0;
    wb_mem_addr       = 32'd0;
    wb_mem_write      = 1'b0;
    wb_mem_to_reg     = 1'b0;
    wb_alu_to_reg     = 1'b0;
    wb_dest_reg_sel   = 5'd0;
    wb_read_address   = 2'd0;
    mem_alu_operation = 3'd0;
    dmem_ready        = 1'b0;
    dmem_rvalid       = 1'b0;
    dmem_rdata        = 32'd0;
  endtask

  // Error pulses are registered: compare against what the previous cycle set up.
  task automatic chk_errs();
    check("misaligned_err", 32'(misaligned_err), 32'(exp_mis));
    check("bus_err", 32'(bus_err), 32'(exp_bus));
    exp_mis = 1'b0;
    exp_bus = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(dmem_req), 0);
    check({tag, "_we"}, 32'(dmem_we), 0);
    check({tag, "_addr"}, dmem_addr, 0);
    check({tag, "_wdata"}, dmem_wdata, 0);
    check({tag, "_be"}, 32'(dmem_be), 0);
    check({tag, "_rf_we"}, 32'(rf_we), 0);
    check({tag, "_rf_waddr"}, 32'(rf_waddr), 0);
    check({tag, "_rf_wdata"}, rf_wdata, 0);
    check({tag, "_fwd_valid"}, 32'(fwd_valid), 0);
    check({tag, "_fwd_data"}, fwd_data, 0);
    check({tag, "_stall"}, 32'(stall_read), 0);
    check({tag, "_mis"}, 32'(misaligned_err), 0);
    check({tag, "_bus"}, 32'(bus_err), 0);
  endtask

  // ---------------- transactions ----------------
  task automatic run_alu(input logic [31:0] res, input logic [4:0] rd, input logic alu);
    clear_inputs();
    wb_result       = res;
    wb_mem_addr     = $urandom();
    wb_read_address = wb_mem_addr[1:0];
    wb_alu_to_reg   = alu;
    wb_dest_reg_sel = rd;
    dmem_rvalid     = 1'($urandom_range(0, 1));  // stray rvalid in IDLE is ignored
    dmem_rdata      = $urandom();
    settle();
    chk_errs();
    check("alu_rf_we", 32'(rf_we), 32'(alu && (rd != 0)));
    check("alu_waddr", 32'(rf_waddr), 32'(rd));
    check("alu_wdata", rf_wdata, res);
    check("alu_fwd_valid", 32'(fwd_valid), 32'(alu && (rd != 0)));
    check("alu_fwd_data", fwd_data, res);
    check("alu_stall", 32'(stall_read), 0);
    check("alu_req", 32'(dmem_req), 0);
    tick();
  endtask

  task automatic run_store(input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] data, input int ready_wait);
    clear_inputs();
    wb_result         = data;
    wb_mem_addr       = addr;
    wb_read_address   = addr[1:0];
    mem_alu_operation = f3;
    wb_mem_write      = 1'b1;
    wb_dest_reg_sel   = 5'($urandom_range(1, 31));
    for (int i = 0; i <= ready_wait; i++) begin
      dmem_ready = (i == ready_wait);
      settle();
      chk_errs();
      check("st_req", 32'(dmem_req), 1);
      check("st_we", 32'(dmem_we), 1);
      check("st_addr", dmem_addr, addr & 32'hFFFF_FFFC);
      check("st_be", 32'(dmem_be), 32'(be_model(f3, addr[1:0])));
      check("st_wdata", dmem_wdata, wdata_model(f3, data));
      check("st_rf_we", 32'(rf_we), 0);
      check("st_stall", 32'(stall_read), 32'(i != ready_wait));
      tick();
    end
  endtask

  // rv_delay = cycles after acceptance until rvalid; above TIMEOUT means never.
  task automatic run_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                          input logic [31:0] rdata, input int ready_wait, input int rv_delay);
    logic [31:0] exp;
    exp = load_model(f3, addr[1:0], rdata);
    clear_inputs();
    wb_result         = $urandom();
    wb_mem_addr       = addr;
    wb_read_address   = addr[1:0];
    mem_alu_operation = f3;
    wb_mem_to_reg     = 1'b1;
    wb_alu_to_reg     = 1'b1;
    wb_dest_reg_sel   = rd;
    dmem_rdata        = rdata;
    for (int i = 0; i < ready_wait; i++) begin
      settle();
      chk_errs();
      check("ld_nrdy_req", 32'(dmem_req), 1);
      check("ld_nrdy_stall", 32'(stall_read), 1);
      check("ld_nrdy_rf_we", 32'(rf_we), 0);
      tick();
    end
    dmem_ready  = 1'b1;
    dmem_rvalid = (rv_delay == 0);
    settle();
    chk_errs();
    check("ld_req", 32'(dmem_req), 1);
    check("ld_we", 32'(dmem_we), 0);
    check("ld_be", 32'(dmem_be), 32'hF);
    check("ld_addr", dmem_addr, addr & 32'hFFFF_FFFC);
    if (rv_delay == 0) begin
      check("ld0_stall", 32'(stall_read), 0);
      check("ld0_rf_we", 32'(rf_we), 32'(rd != 0));
      check("ld0_wdata", rf_wdata, exp);
      check("ld0_fwd", fwd_data, exp);
      tick();
      return;
    end
    check("ld_acc_stall", 32'(stall_read), 1);
    check("ld_acc_rf_we", 32'(rf_we), 0);
    tick();
    dmem_ready = 1'b0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      dmem_rvalid = (c == rv_delay);
      settle();
      chk_errs();
      check("lw_req", 32'(dmem_req), 0);
      if (c == rv_delay) begin
        check("lw_done_stall", 32'(stall_read), 0);
        check("lw_done_rf_we", 32'(rf_we), 32'(rd != 0));
        check("lw_done_waddr", 32'(rf_waddr), 32'(rd));
        check("lw_done_wdata", rf_wdata, exp);
        check("lw_done_fwd_valid", 32'(fwd_valid), 32'(rd != 0));
        tick();
        return;
      end
      if (c == TIMEOUT) begin
        check("lw_to_stall", 32'(stall_read), 0);
        check("lw_to_rf_we", 32'(rf_we), 0);
        exp_bus = 1'b1;
        tick();
        return;
      end
      check("lw_stall", 32'(stall_read), 1);
      check("lw_rf_we", 32'(rf_we), 0);
      tick();
    end
  endtask

  task automatic run_misaligned(input logic [2:0] f3, input logic [31:0] addr, input logic st);
    clear_inputs();
    wb_result         = $urandom();
    wb_mem_addr       = addr;
    wb_read_address   = addr[1:0];
    mem_alu_operation = f3;
    wb_mem_write      = st;
    wb_mem_to_reg     = !st;
    wb_alu_to_reg     = !st;
    wb_dest_reg_sel   = 5'($urandom_range(1, 31));
    dmem_ready        = 1'b1;
    settle();
    chk_errs();
    check("mis_req", 32'(dmem_req), 0);
    check("mis_rf_we", 32'(rf_we), 0);
    check("mis_stall", 32'(stall_read), 0);
    exp_mis = 1'b1;
    tick();
  endtask

  function automatic logic [1:0] aligned_off(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'($urandom_range(0, 3));
      2'b01:   return 2'($urandom_range(0, 1) * 2);
      default: return 2'd0;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind;

    // Reset with all-zero EX->WB contents: everything quiet.
    reset = 1'b0;
    clear_inputs();
    settle();
    check_all_zero("reset");
    tick();
    tick();
    reset = 1'b1;

    // ADD with rd=5, then rd=0.
    run_alu(32'h0000_1234, 5'd5, 1'b1);
    run_alu(32'h0000_1234, 5'd0, 1'b1);

    // SB at 0x103 with two not-ready cycles.
    run_store(3'd0, 32'h0000_0103, 32'h0000_00AB, 2);

    // LB / LBU at offset 2, rvalid three cycles after acceptance.
    run_load(3'd0, 32'h0000_0202, 5'd7, 32'h0080_0000, 0, 3);
    run_load(3'd4, 32'h0000_0202, 5'd7, 32'h0080_0000, 0, 3);

    // Misaligned LH at offset 1, then SH at offset 2.
    run_misaligned(3'd1, 32'h0000_0301, 1'b0);
    run_store(3'd1, 32'h0000_0302, 32'h0000_BEEF, 0);

    // LW timeout, then LW with rvalid in the last allowed cycle.
    run_load(3'd2, 32'h0000_0400, 5'd3, 32'h1111_2222, 0, TIMEOUT + 1);
    run_load(3'd2, 32'h0000_0404, 5'd3, 32'hCAFE_F00D, 0, TIMEOUT);
    run_alu(32'h0000_0042, 5'd1, 1'b1);

    // Reset while in LOAD_WAIT: in-flight load dropped, late rvalid ignored.
    clear_inputs();
    wb_mem_addr     = 32'h0000_0500;
    wb_mem_to_reg   = 1'b1;
    wb_alu_to_reg   = 1'b1;
    wb_dest_reg_sel = 5'd9;
    mem_alu_operation = 3'd2;
    dmem_ready      = 1'b1;
    settle();
    chk_errs();
    check("rst_ld_stall", 32'(stall_read), 1);
    tick();
    dmem_ready = 1'b0;
    tick();
    reset = 1'b0;
    clear_inputs();
    settle();
    check_all_zero("rst_lw");
    tick();
    reset = 1'b1;
    clear_inputs();
    wb_dest_reg_sel = 5'd9;
    dmem_rvalid     = 1'b1;
    dmem_rdata      = 32'hDEAD_BEEF;
    settle();
    chk_errs();
    check("late_rv_rf_we", 32'(rf_we), 0);
    check("late_rv_stall", 32'(stall_read), 0);
    check("late_rv_req", 32'(dmem_req), 0);
    tick();

    // Randomized transactions.
    for (int t = 0; t < 80; t++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom();
      case (kind)
        0: run_alu($urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
        1: begin
          f3      = 3'($urandom_range(0, 2));
          a[1:0]  = aligned_off(f3);
          run_store(f3, a, $urandom(), $urandom_range(0, 3));
        end
        2: begin
          case ($urandom_range(0, 4))
            0:       f3 = 3'd0;
            1:       f3 = 3'd1;
            2:       f3 = 3'd2;
            3:       f3 = 3'd4;
            default: f3 = 3'd5;
          endcase
          a[1:0] = aligned_off(f3);
          run_load(f3, a, 5'($urandom_range(0, 31)), $urandom(), $urandom_range(0, 2),
                   $urandom_range(0, TIMEOUT + 2));
        end
        default: begin
          if ($urandom_range(0, 1) == 0) begin
            f3     = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'd5;
            a[1:0] = ($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3;
          end else begin
            f3     = 3'd2;
            a[1:0] = 2'($urandom_range(1, 3));
          end
          run_misaligned(f3, a, 1'($urandom_range(0, 1)));
        end
      endcase
    end

    // Final bubble to observe any pending error pulse.
    run_alu(32'd0, 5'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
